// File: rtl/debug_pkg.sv
// Shared definitions for the debug unit: host command bytes, the ACK byte,
// the HALT instruction encoding, the sequencer state encoding and the
// number of words in a state dump (PC followed by 32 registers).
package debug_pkg;

  localparam logic [7:0]  CMD_LOAD   = 8'h4C;  // 'L'
  localparam logic [7:0]  CMD_CONT   = 8'h43;  // 'C'
  localparam logic [7:0]  CMD_STEP   = 8'h53;  // 'S'
  localparam logic [7:0]  ACK_BYTE   = 8'h06;
  localparam logic [31:0] HALT_WORD  = 32'h0000_003F;
  localparam int          DUMP_WORDS = 33;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_ACK,
    ST_RUN,
    ST_STEP,
    ST_DUMP_LATCH,
    ST_DUMP_TX
  } state_t;

endpackage

// File: rtl/debug_tx_serializer.sv
// Word-to-byte serializer for the state dump.
//   i_load  : capture i_data and start offering its bytes, MSB first
//   o_valid : a byte is offered on o_data
//   i_ready : transmitter accepts; a byte moves when o_valid && i_ready
//   o_done  : combinational, high on the handshake of the last byte
module debug_tx_serializer #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_valid,
  output logic [NB_BYTE-1:0] o_data,
  input  logic               i_ready,
  output logic               o_done
);

  localparam int NB_CNT = $clog2(NB_DATA / NB_BYTE);
  localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(NB_DATA / NB_BYTE - 1);

  logic [NB_DATA-1:0] shift;
  logic [NB_CNT-1:0]  cnt;
  logic               busy;
  logic               last;

  assign last    = (cnt == LAST_BYTE);
  assign o_valid = busy;
  assign o_data  = shift[NB_DATA-1 -: NB_BYTE];
  assign o_done  = busy && i_ready && last;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always blocks are evaluated.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (i_load) begin
      shift <= i_data;
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (busy && i_ready) begin
      if (last) begin
        busy <= 1'b0;
      end else begin
        // The byte on o_data only changes on a handshake, so it stays
        // stable while the transmitter back-pressures.
        shift <= shift << NB_BYTE;
        cnt   <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/debug_unit_ctrl.sv
// Host-side sequencer for the MIPS pipeline.
// Takes byte commands from the UART receiver: 'L' loads program words into
// instruction memory (4 bytes per word, MSB first, ended by HALT or a full
// memory, answered with ACK), 'C' runs until a HALT retires, 'S' advances the
// pipeline by one clock. After every run/step the PC and the 32 registers
// are streamed back MSB first (132 bytes).
// Ports:
//   i_clk, i_rst_n              clock, async active-low reset
//   i_rx_valid, i_rx_data       received byte (one-cycle pulse)
//   o_tx_valid, o_tx_data,
//   i_tx_ready                  byte stream to the UART transmitter
//   o_pipe_enable               pipeline advance enable
//   i_halt, i_pc                HALT retiring in write-back, current PC
//   o_reg_addr, i_reg_data      register-file debug read port
//   o_imem_we/addr/data         instruction-memory write port
module debug_unit_ctrl
  import debug_pkg::*;
#(
  parameter int NB_DATA      = 32,
  parameter int NB_BYTE      = 8,
  parameter int NB_IMEM_ADDR = 8,
  parameter int NB_REG_ADDR  = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_rx_valid,
  input  logic [NB_BYTE-1:0]      i_rx_data,
  output logic                    o_tx_valid,
  output logic [NB_BYTE-1:0]      o_tx_data,
  input  logic                    i_tx_ready,
  output logic                    o_pipe_enable,
  input  logic                    i_halt,
  input  logic [NB_DATA-1:0]      i_pc,
  output logic [NB_REG_ADDR-1:0]  o_reg_addr,
  input  logic [NB_DATA-1:0]      i_reg_data,
  output logic                    o_imem_we,
  output logic [NB_IMEM_ADDR-1:0] o_imem_addr,
  output logic [NB_DATA-1:0]      o_imem_data
);

  localparam int NB_BCNT = $clog2(NB_DATA / NB_BYTE);
  localparam int NB_IDX  = $clog2(DUMP_WORDS);
  localparam logic [NB_BCNT-1:0] LAST_RX_BYTE = NB_BCNT'(NB_DATA / NB_BYTE - 1);
  localparam logic [NB_IDX-1:0]  LAST_IDX     = NB_IDX'(DUMP_WORDS - 1);

  state_t                  state, state_next;
  logic                    halted;
  logic [NB_IMEM_ADDR-1:0] addr_cnt;
  logic [NB_BCNT-1:0]      byte_cnt;
  logic [NB_DATA-1:0]      word;
  logic [NB_IDX-1:0]       dump_idx;
  logic [NB_DATA-1:0]      dump_word;

  logic                    ser_load;
  logic                    ser_valid;
  logic [NB_BYTE-1:0]      ser_data;
  logic                    ser_done;

  // Index 0 of the dump is the PC; index k is register k-1.
  assign o_reg_addr    = (dump_idx == '0) ? '0 : NB_REG_ADDR'(dump_idx - 1'b1);
  assign dump_word     = (dump_idx == '0) ? i_pc : i_reg_data;

  assign o_pipe_enable = (state == ST_RUN) || (state == ST_STEP);
  assign o_imem_we     = (state == ST_WRITE);
  assign o_imem_addr   = addr_cnt;
  assign o_imem_data   = word;

  debug_tx_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_tx_serializer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (ser_load),
    .i_data  (dump_word),
    .o_valid (ser_valid),
    .o_data  (ser_data),
    .i_ready (i_tx_ready),
    .o_done  (ser_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    ser_load   = 1'b0;
    o_tx_valid = 1'b0;
    o_tx_data  = '0;
    case (state)
      ST_IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == NB_BYTE'(CMD_LOAD)) begin
            state_next = ST_LOAD;
          end else if (i_rx_data == NB_BYTE'(CMD_CONT)) begin
            state_next = halted ? ST_DUMP_LATCH : ST_RUN;
          end else if (i_rx_data == NB_BYTE'(CMD_STEP)) begin
            state_next = halted ? ST_DUMP_LATCH : ST_STEP;
          end
        end
      end
      ST_LOAD: begin
        if (i_rx_valid && (byte_cnt == LAST_RX_BYTE)) begin
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // A full memory ends the load even without a HALT word, so the
        // address counter never wraps onto word 0.
        if ((word == NB_DATA'(HALT_WORD)) || (addr_cnt == '1)) begin
          state_next = ST_ACK;
        end else begin
          state_next = ST_LOAD;
        end
      end
      ST_ACK: begin
        o_tx_valid = 1'b1;
        o_tx_data  = NB_BYTE'(ACK_BYTE);
        if (i_tx_ready) begin
          state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (i_halt) begin
          state_next = ST_DUMP_LATCH;
        end
      end
      ST_STEP: begin
        state_next = ST_DUMP_LATCH;
      end
      ST_DUMP_LATCH: begin
        ser_load   = 1'b1;
        state_next = ST_DUMP_TX;
      end
      ST_DUMP_TX: begin
        o_tx_valid = ser_valid;
        o_tx_data  = ser_data;
        if (ser_done) begin
          state_next = (dump_idx == LAST_IDX) ? ST_IDLE : ST_DUMP_LATCH;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      halted   <= 1'b0;
      addr_cnt <= '0;
      byte_cnt <= '0;
      word     <= '0;
      dump_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_rx_valid && (i_rx_data == NB_BYTE'(CMD_LOAD))) begin
            halted   <= 1'b0;
            addr_cnt <= '0;
            byte_cnt <= '0;
          end
        end
        ST_LOAD: begin
          if (i_rx_valid) begin
            word     <= {word[NB_DATA-NB_BYTE-1:0], i_rx_data};
            byte_cnt <= byte_cnt + 1'b1;
          end
        end
        ST_WRITE: addr_cnt <= addr_cnt + 1'b1;
        ST_RUN, ST_STEP: begin
          if (i_halt) begin
            halted <= 1'b1;
          end
        end
        ST_DUMP_TX: begin
          if (ser_done) begin
            dump_idx <= (dump_idx == LAST_IDX) ? '0 : dump_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// Self-checking bench for debug_unit_ctrl. A behavioural register file and
// PC feed the dump; expected byte streams and write sequences are built from
// the command rules and compared with what a negedge monitor collects.
module tb_debug_unit_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        pipe_enable;
  logic        halt;
  logic [31:0] pc;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;

  logic [31:0] regs [32];
  assign reg_data = regs[reg_addr];

  always #5 clk = ~clk;

  debug_unit_ctrl dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_rx_valid    (rx_valid),
    .i_rx_data     (rx_data),
    .o_tx_valid    (tx_valid),
    .o_tx_data     (tx_data),
    .i_tx_ready    (tx_ready),
    .o_pipe_enable (pipe_enable),
    .i_halt        (halt),
    .i_pc          (pc),
    .o_reg_addr    (reg_addr),
    .i_reg_data    (reg_data),
    .o_imem_we     (imem_we),
    .o_imem_addr   (imem_addr),
    .o_imem_data   (imem_data)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  tx_q[$];
  logic [39:0] wr_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] ld_q[$];
  int          en_cnt = 0;
  bit          rand_ready = 0;
  bit          stall_prev = 0;
  logic [7:0]  stall_data;

  // Monitor: negedge values are what the next rising edge will act on.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_valid && tx_ready) tx_q.push_back(tx_data);
      if (imem_we) wr_q.push_back({imem_addr, imem_data});
      if (pipe_enable) en_cnt++;
      if (stall_prev) begin
        n_tests++;
        if (!(tx_valid === 1'b1 && tx_data === stall_data)) begin
          n_fail++;
          $display("FAIL tx_hold: valid=%b data=%h, required valid=1 data=%h",
                   tx_valid, tx_data, stall_data);
        end
      end
      stall_prev = tx_valid && !tx_ready;
      stall_data = tx_data;
    end else begin
      stall_prev = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    tx_q.delete();
    wr_q.delete();
    en_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  // New random PC/register contents and the 132-byte dump they must produce.
  task automatic new_state_model();
    pc = $urandom;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    exp_q.delete();
    for (int b = 3; b >= 0; b--) exp_q.push_back(pc[b*8 +: 8]);
    for (int r = 0; r < 32; r++)
      for (int b = 3; b >= 0; b--) exp_q.push_back(regs[r][b*8 +: 8]);
  endtask

  task automatic wait_tx(input int n, input int budget, input bit inject);
    int c;
    c = 0;
    while (c < budget && tx_q.size() < n) begin
      tx_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (inject && c == 5) begin
        rx_valid = 1'b1; rx_data = 8'h53;
      end else if (inject && c == 9) begin
        rx_valid = 1'b1; rx_data = 8'h4C;
      end else begin
        rx_valid = 1'b0;
      end
      tick();
      c++;
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    n_tests++;
    if (tx_q.size() < n) begin
      n_fail++;
      $display("FAIL tx_timeout: got %0d bytes, required %0d", tx_q.size(), n);
    end
  endtask

  task automatic compare_dump(input string name);
    int bad;
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad < 0 && (i >= tx_q.size() || tx_q[i] !== exp_q[i])) bad = i;
    n_tests++;
    if (bad >= 0 || tx_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s: %0d bytes (required %0d), first bad index %0d got %h required %h",
               name, tx_q.size(), exp_q.size(), bad,
               (bad >= 0 && bad < tx_q.size()) ? tx_q[bad] : 8'hxx,
               (bad >= 0) ? exp_q[bad] : 8'hxx);
    end
  endtask

  // Sends 'L' and the words in ld_q, checking write and ACK latency inline.
  task automatic load_words();
    bit ends;
    send_byte(8'h4C);
    for (int i = 0; i < ld_q.size(); i++) begin
      for (int b = 3; b >= 0; b--) send_byte(ld_q[i][b*8 +: 8]);
      n_tests++;
      if (imem_we !== 1'b1 || imem_addr !== 8'(i) || imem_data !== ld_q[i]) begin
        n_fail++;
        $display("FAIL load_write[%0d]: we=%b addr=%h data=%h, required we=1 addr=%h data=%h",
                 i, imem_we, imem_addr, imem_data, 8'(i), ld_q[i]);
      end
      ends = (ld_q[i] == 32'h3F) || (i == 255);
      tick();
      n_tests++;
      if (tx_valid !== ends || (ends && tx_data !== 8'h06)) begin
        n_fail++;
        $display("FAIL load_ack[%0d]: valid=%b data=%h, required valid=%b",
                 i, tx_valid, tx_data, ends);
      end
      if (ends) tick();
    end
  endtask

  task automatic check_writes(input string name);
    bit ok;
    ok = (wr_q.size() == ld_q.size());
    for (int i = 0; i < wr_q.size() && ok; i++)
      if (wr_q[i] !== {8'(i), ld_q[i]}) ok = 0;
    n_tests++;
    if (!ok || tx_q.size() != 1 || tx_q[0] !== 8'h06) begin
      n_fail++;
      $display("FAIL %s: %0d writes (required %0d), %0d tx bytes (required 1 ACK)",
               name, wr_q.size(), ld_q.size(), tx_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b1; halt = 1'b0;
    pc = '0;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    repeat (3) tick();
    n_tests++;
    if ({pipe_enable, tx_valid, tx_data, imem_we, imem_addr, imem_data, reg_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_in: outputs %h, required 0",
               {pipe_enable, tx_valid, tx_data, imem_we, imem_addr, imem_data, reg_addr});
    end
    rst_n = 1'b1;
    repeat (2) tick();
    n_tests++;
    if ({pipe_enable, tx_valid, tx_data, imem_we, imem_addr, imem_data, reg_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_out: outputs %h, required 0",
               {pipe_enable, tx_valid, tx_data, imem_we, imem_addr, imem_data, reg_addr});
    end
  endtask

  task automatic test_load();
    clear_mon();
    ld_q.delete();
    ld_q.push_back(32'h2001_0005);
    for (int i = 0; i < 3; i++) ld_q.push_back($urandom & 32'hFFFF_FF00);
    ld_q.push_back(32'h0000_003F);
    load_words();
    repeat (5) tick();
    check_writes("load");
  endtask

  task automatic test_step();
    new_state_model();
    clear_mon();
    rand_ready = 1;
    send_byte(8'h53);
    n_tests++;
    if (pipe_enable !== 1'b1) begin
      n_fail++; $display("FAIL step_en: enable=%b, required 1", pipe_enable);
    end
    tick();
    n_tests++;
    if (pipe_enable !== 1'b0 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL step_latch: enable=%b valid=%b, required 0 0", pipe_enable, tx_valid);
    end
    tick();
    n_tests++;
    if (tx_valid !== 1'b1 || tx_data !== exp_q[0]) begin
      n_fail++;
      $display("FAIL step_first: valid=%b data=%h, required 1 %h", tx_valid, tx_data, exp_q[0]);
    end
    wait_tx(132, 2000, 0);
    compare_dump("step_dump");
    n_tests++;
    if (en_cnt != 1) begin
      n_fail++; $display("FAIL step_en_cnt: %0d, required 1", en_cnt);
    end
  endtask

  task automatic test_run();
    new_state_model();
    clear_mon();
    send_byte(8'h43);
    repeat (19) tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    wait_tx(132, 2000, 0);
    compare_dump("run_dump");
    n_tests++;
    if (en_cnt != 20) begin
      n_fail++; $display("FAIL run_en_cnt: %0d, required 20", en_cnt);
    end
    new_state_model();
    clear_mon();
    send_byte(8'h43);
    wait_tx(132, 2000, 0);
    compare_dump("halted_dump");
    n_tests++;
    if (en_cnt != 0) begin
      n_fail++; $display("FAIL halted_en_cnt: %0d, required 0", en_cnt);
    end
  endtask

  task automatic test_back_pressure();
    new_state_model();
    clear_mon();
    rand_ready = 0;
    send_byte(8'h43);
    wait_tx(10, 200, 0);
    tx_ready = 1'b0;
    repeat (5) tick();
    n_tests++;
    if (tx_q.size() != 10) begin
      n_fail++; $display("FAIL bp_stall: %0d bytes, required 10", tx_q.size());
    end
    tx_ready = 1'b1;
    wait_tx(132, 2000, 0);
    compare_dump("bp_dump");
    rand_ready = 1;
  endtask

  task automatic test_robust();
    clear_mon();
    send_byte(8'h58);
    repeat (10) tick();
    n_tests++;
    if (tx_q.size() != 0 || wr_q.size() != 0 || en_cnt != 0) begin
      n_fail++;
      $display("FAIL bad_cmd: tx=%0d wr=%0d en=%0d, required 0 0 0",
               tx_q.size(), wr_q.size(), en_cnt);
    end
    new_state_model();
    clear_mon();
    send_byte(8'h43);
    wait_tx(132, 2000, 1);
    compare_dump("inject_dump");
    repeat (20) tick();
    n_tests++;
    if (tx_q.size() != 132 || wr_q.size() != 0 || en_cnt != 0) begin
      n_fail++;
      $display("FAIL inject_after: tx=%0d wr=%0d en=%0d, required 132 0 0",
               tx_q.size(), wr_q.size(), en_cnt);
    end
    // Reload clears halted so 'C' really runs, then reset mid-run.
    ld_q.delete();
    ld_q.push_back(32'h0000_003F);
    load_words();
    send_byte(8'h43);
    repeat (3) tick();
    n_tests++;
    if (pipe_enable !== 1'b1) begin
      n_fail++; $display("FAIL rst_run_pre: enable=%b, required 1", pipe_enable);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({pipe_enable, tx_valid, tx_data, imem_we, imem_addr, imem_data, reg_addr} !== '0) begin
      n_fail++;
      $display("FAIL rst_run: outputs %h, required 0",
               {pipe_enable, tx_valid, tx_data, imem_we, imem_addr, imem_data, reg_addr});
    end
    tick();
    rst_n = 1'b1;
    tick();
    new_state_model();
    clear_mon();
    send_byte(8'h53);
    n_tests++;
    if (pipe_enable !== 1'b1) begin
      n_fail++; $display("FAIL rst_halted: enable=%b after step, required 1", pipe_enable);
    end
    wait_tx(132, 2000, 0);
    compare_dump("rst_step_dump");
  endtask

  task automatic test_addr_wrap();
    logic [31:0] w;
    clear_mon();
    ld_q.delete();
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if (w == 32'h3F) w = 32'h0;
      ld_q.push_back(w);
    end
    load_words();
    repeat (10) tick();
    check_writes("wrap");
  endtask

  initial begin
    test_reset();
    test_load();
    test_step();
    test_run();
    test_back_pressure();
    test_robust();
    test_addr_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
